// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer that runs a WIDTH-bit ALU operation through an external 1-bit slice,
// one bit per clock, LSB first, with a registered carry chain and a done pulse.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic [3:0]       slice_sel_o,
    input  logic             slice_f_i,
    input  logic             slice_cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [3:0]         sel_reg;
    logic               carry_reg;
    logic               prev_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   coll_reg;
    logic [WIDTH-1:0]   coll_next;
    logic [WIDTH-1:0]   result_reg;
    logic               cout_reg;

    logic               accept;
    logic               running;
    logic               last_bit;
    logic [1:0]         op_class;
    logic               new_bit;

    assign accept   = (state_reg == IDLE) && req_valid_i;
    assign running  = (state_reg == RUN);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    assign op_class = sel_reg[3:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid_i) state_next = RUN;
            RUN:     if (last_bit)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift classes generate the bit locally; the slice output is not trusted for them.
    always_comb begin
        new_bit = slice_f_i;
        case (op_class)
            2'b10:   new_bit = last_bit ? 1'b0 : a_sh_reg[1];
            2'b11:   new_bit = prev_reg;
            default: new_bit = slice_f_i;
        endcase
    end

    assign coll_next = {new_bit, coll_reg[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sel_reg    <= '0;
            carry_reg  <= 1'b0;
            prev_reg   <= 1'b0;
            cnt_reg    <= '0;
            coll_reg   <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a_i;
            b_sh_reg  <= b_i;
            sel_reg   <= sel_i;
            carry_reg <= cin_i;
            prev_reg  <= 1'b0;
            cnt_reg   <= '0;
            coll_reg  <= '0;
        end else if (running) begin
            a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
            prev_reg <= a_sh_reg[0];
            coll_reg <= coll_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (op_class == 2'b00) begin
                carry_reg <= slice_cout_i;
            end
            if (last_bit) begin
                result_reg <= coll_next;
                cout_reg   <= (op_class == 2'b00) && slice_cout_i;
            end
        end
    end

    // Slice inputs are quiet outside RUN; the select keeps its last value.
    assign slice_a_o   = running && a_sh_reg[0];
    assign slice_b_o   = running && b_sh_reg[0];
    assign slice_cin_o = running && carry_reg;
    assign slice_sel_o = sel_reg;

    assign req_ready_o = (state_reg == IDLE);
    assign done_o      = (state_reg == DONE);
    assign result_o    = result_reg;
    assign cout_o      = cout_reg;

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequencer that runs a full WIDTH-bit ALU operation through a single external 1-bit ALU slice, one bit per clock, LSB first. It accepts an operation request (operands, carry-in, 4-bit select), drives the slice's bit inputs and select every cycle, and chains the carry through an internal register. It collects the result bits into a word, then returns the result with a final carry-out through a valid/ready-style handshake. It sits between the word-level command source and the combinational 1-bit slice, so the slice serves as a WIDTH-bit ALU.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- req_valid_i  input  1  operation request present
- req_ready_o  output  1  controller can accept a request (high only in IDLE)
- a_i  input  WIDTH  operand A, sampled on accept
- b_i  input  WIDTH  operand B, sampled on accept
- cin_i  input  1  carry-in for bit 0, sampled on accept
- sel_i  input  4  operation select, sampled on accept; [3:2] class (00 arith, 01 logic, 10 shift right, 11 shift left), [1:0] sub-op forwarded to slice
- slice_a_o  output  1  A bit to slice
- slice_b_o  output  1  B bit to slice
- slice_cin_o  output  1  carry bit to slice
- slice_sel_o  output  4  select to slice (registered copy of sel_i)
- slice_f_i  input  1  slice result bit (combinational response to slice_*_o, same cycle)
- slice_cout_i  input  1  slice carry-out, same cycle
- result_o  output  WIDTH  result word; held stable until the next accept
- cout_o  output  1  final carry-out; 0 for non-arithmetic classes
- done_o  output  1  one-cycle pulse: result_o/cout_o are newly valid

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. IDLE→RUN on req_valid_i & req_ready_o (accept). RUN→DONE when the bit counter equals WIDTH-1 at the clock edge. DONE→IDLE unconditionally after one cycle.
- On accept: latch a_i, b_i, sel_i into shift/hold registers. Set carry register = cin_i, bit counter = 0, prev-bit register = 0. Clear result shift register.
- RUN, each cycle: slice_a_o = A_sh[0], slice_b_o = B_sh[0], slice_cin_o = carry register, slice_sel_o = latched sel. At the edge: shift A_sh and B_sh right by 1 (zero fill), prev-bit = old A_sh[0], shift the new bit into result MSB (right-shifting collector), counter += 1.
- New result bit by class:
  - 00: slice_f_i; carry register ← slice_cout_i.
  - 01: slice_f_i; carry register unchanged.
  - 10 (shift right by 1): A_sh[1] (0 at the last bit); slice_f_i ignored.
  - 11 (shift left by 1): prev-bit register (0 at bit 0); slice_f_i ignored.
- On the RUN→DONE edge: result_o ← completed collector. cout_o ← slice_cout_i of bit WIDTH-1 for class 00. For every other class, cout_o ← 0.
- req_valid_i while not in IDLE: ignored, not queued. Request fields are don't-care outside accept.
- slice_*_o in IDLE/DONE: slice_a_o = slice_b_o = slice_cin_o = 0; slice_sel_o holds its last value.

## Timing
- Reset values: req_ready_o = 1, result_o = 0, cout_o = 0, done_o = 0, slice_a_o = slice_b_o = slice_cin_o = 0, slice_sel_o = 0, state IDLE.
- req_ready_o is a decode of state IDLE. It does not depend combinationally on req_valid_i.
- Accept at edge T0. Bit i is presented to the slice in cycle T0+1+i. done_o is high in cycle T0+WIDTH+1. req_ready_o returns high in cycle T0+WIDTH+2. Issue interval is WIDTH+2 cycles.
- result_o/cout_o change only at the RUN→DONE edge and reset.
- rst_i asserted in any state, including mid-RUN: at the next edge, go to IDLE with all reset values. The partial result is discarded and no done_o is produced. rst_i has priority over accept.
- Carry chain is purely registered; there is no combinational path from slice_cout_i to slice_cin_o.

## Test plan
- Reset mid-RUN of a WIDTH=32 add at bit 10 → next cycle req_ready_o=1, done_o never pulses, result_o=0, cout_o=0.
- Bench slice model with sel 4'b0000 = A+B+cin. Request a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 → done_o at accept+33, result_o=32'h0000_0000, cout_o=1.
- Model sel 4'b0100 = AND. Request a=32'hF0F0_1234, b=32'h0FF0_FFFF, cin=1 → result_o=32'h00F0_1234, cout_o=0. The carry register must not affect the result.
- sel=4'b1000, a=32'h8000_0003 → result_o=32'h4000_0001. sel=4'b1100, a=32'h8000_0003 → result_o=32'h0000_0006, cout_o=0. Slice output is forced to X by the bench and must be ignored.
- Back-to-back requests with req_valid_i held high → accepts spaced exactly 34 cycles apart. Requests presented during RUN/DONE are not accepted, and result_o stays stable between the done_o pulses.
- WIDTH=2, add a=2'b11, b=2'b01, cin=1 → result_o=2'b01, cout_o=1, done_o at accept+3.
